cv32e40p_ft_redundancy_ctrl: RTL and testbench
==============================================

// Module: cv32e40p_ft_redundancy_ctrl
// PURPOSE
//  Supervisor for one TMR-protected block (e.g. the fault-tolerant compressed decoder).
//  Watches the per-replica is_broken flags and the voter error flags, and tracks the redundancy state.
//  Sequences software-requested replica retirement onto set_broken via a req/ack handshake.
//  Keeps saturating error statistics and raises a halt request when redundancy is lost.
// PARAMETERS
//  ERR_CNT_W     16  width of the detected/corrected error counters
//  UNCORR_LIMIT  4   consecutive detected-but-uncorrected cycles that force FATAL (>=1)
//  FORCE_HOLD    2   cycles set_broken_o is held high per accepted request (>=1)
// PORTS
//  clk           in   1          clock
//  rst           in   1          synchronous reset, active-high
//  is_broken_i   in   3          per-replica broken flags from the breakage monitors
//  err_detected_i in  1          voter detected a mismatch this cycle
//  err_corrected_i in 1          voter corrected the mismatch this cycle
//  cfg_req_i     in   1          software retire request (level, held until ack)
//  cfg_mask_i    in   3          replicas to retire; sampled when the request is accepted
//  cfg_ack_o     out  1          one-cycle acknowledge of the request
//  cfg_err_o     out  1          valid with cfg_ack_o: 1 = request rejected
//  set_broken_o  out  3          to the breakage monitors' set_broken_i
//  state_o       out  2          00 NOMINAL, 01 DEGRADED, 10 FATAL
//  halt_req_o    out  1          high while state_o==FATAL
//  det_cnt_o     out  ERR_CNT_W  saturating count of err_detected_i cycles
//  corr_cnt_o    out  ERR_CNT_W  saturating count of err_corrected_i cycles
//  clr_cnt_i     in   1          clears both counters
// BEHAVIOUR
//  Reset: state_o=NOMINAL; all other outputs are 0; the cfg FSM returns to IDLE and the uncorrected-run counter is 0.
//  Reset mid-sequence aborts any set_broken pulse, and no ack is issued.
//  Redundancy FSM (all outputs registered; 1-cycle latency from the inputs):
//   nb = popcount(is_broken_i).
//   NOMINAL : nb==1 -> DEGRADED; nb>=2 or uncorrectable -> FATAL.
//   DEGRADED: nb>=2 or uncorrectable -> FATAL; nb==0 -> NOMINAL (monitor recovered).
//   FATAL   : sticky; left only on rst.
//   uncorrectable = run counter reaches UNCORR_LIMIT. The run counter increments on err_detected_i & ~err_corrected_i.
//   It clears on any other cycle and saturates at UNCORR_LIMIT.
//  Cfg sequencer: IDLE -> DRIVE -> ACK -> WAIT.
//   IDLE : on cfg_req_i, latch m = cfg_mask_i.
//          Reject if m==0, or popcount(m | is_broken_i) >= 2, or state is FATAL.
//          Reject -> ACK with cfg_err_o=1; accept -> DRIVE.
//   DRIVE: set_broken_o = m for exactly FORCE_HOLD cycles, then -> ACK.
//   ACK  : cfg_ack_o=1 for one cycle; cfg_err_o is valid here only. Then -> WAIT.
//   WAIT : stay until cfg_req_i==0, then -> IDLE. A new request needs req to deassert first.
//   The breakage monitors may themselves break a replica while the sequencer is in DRIVE.
//   The redundancy FSM still evaluates nb normally, so FATAL can result. The DRIVE sequence still completes.
//  Counters:
//   +1 per cycle when the flag is high; hold at 2^ERR_CNT_W-1 with no wrap.
//   clr_cnt_i has priority over a same-cycle increment, so the result is 0.
//  set_broken_o is 0 outside DRIVE. halt_req_o equals (state_o==FATAL).
// TESTING
//  1. No faults for 100 cycles -> state_o=00, det_cnt_o=0, set_broken_o=0.
//  2. is_broken_i=001 at cycle t -> state_o=01 at t+1. Then 011 -> state_o=10 and halt_req_o=1 next cycle. Clearing is_broken_i keeps 10.
//  3. err_detected_i=1, err_corrected_i=0 for 3 cycles then 1 correct cycle, with UNCORR_LIMIT=4 -> state stays 00.
//     Then 4 consecutive uncorrected cycles -> state 10.
//  4. cfg_req_i=1 with mask=100 and is_broken_i=000 -> set_broken_o=100 for 2 cycles, then cfg_ack_o=1 with cfg_err_o=0.
//     No second ack until req drops and rises again.
//  5. mask=010 with is_broken_i=001 -> ack with cfg_err_o=1 and set_broken_o never asserted. mask=000 -> also rejected.
//  6. ERR_CNT_W=4 with err_detected_i held 20 cycles -> det_cnt_o=15.
//     Assert clr_cnt_i together with err_detected_i -> det_cnt_o=0. rst during DRIVE -> set_broken_o=0 the next cycle and no ack.

Source files
------------

// File: rtl/cv32e40p_ft_redundancy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_ft_redundancy_ctrl
// Purpose  : Supervisor for one TMR-protected block. Tracks the redundancy
//            state from the per-replica broken flags and the voter error
//            flags, sequences software replica retirement onto set_broken_o
//            through a req/ack handshake, keeps saturating error statistics
//            and requests a halt once redundancy is lost.
// Ports    : clk, rst           clock, synchronous active-high reset
//            is_broken_i[2:0]   per-replica broken flags
//            err_detected_i     voter saw a mismatch this cycle
//            err_corrected_i    voter corrected the mismatch this cycle
//            cfg_req_i          software retire request (level)
//            cfg_mask_i[2:0]    replicas to retire, sampled on acceptance
//            cfg_ack_o          one-cycle acknowledge
//            cfg_err_o          request rejected (valid with cfg_ack_o)
//            set_broken_o[2:0]  forced-break strobe to the breakage monitors
//            state_o[1:0]       00 NOMINAL, 01 DEGRADED, 10 FATAL
//            halt_req_o         high while FATAL
//            det_cnt_o          saturating count of detected-error cycles
//            corr_cnt_o         saturating count of corrected-error cycles
//            clr_cnt_i          clears both counters
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_ft_redundancy_ctrl #(
  parameter int unsigned ERR_CNT_W    = 16,
  parameter int unsigned UNCORR_LIMIT = 4,
  parameter int unsigned FORCE_HOLD   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           is_broken_i,
  input  logic                 err_detected_i,
  input  logic                 err_corrected_i,
  input  logic                 cfg_req_i,
  input  logic [2:0]           cfg_mask_i,
  output logic                 cfg_ack_o,
  output logic                 cfg_err_o,
  output logic [2:0]           set_broken_o,
  output logic [1:0]           state_o,
  output logic                 halt_req_o,
  output logic [ERR_CNT_W-1:0] det_cnt_o,
  output logic [ERR_CNT_W-1:0] corr_cnt_o,
  input  logic                 clr_cnt_i
);

  // Widths of the internal run and hold counters
  localparam int unsigned c_run_w  = $clog2(UNCORR_LIMIT + 1);
  localparam int unsigned c_hold_w = (FORCE_HOLD > 1) ? $clog2(FORCE_HOLD) : 1;

  localparam logic [c_run_w-1:0]   c_run_max = c_run_w'(UNCORR_LIMIT);
  localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(FORCE_HOLD - 1);
  localparam logic [ERR_CNT_W-1:0] c_cnt_max = {ERR_CNT_W{1'b1}};

  // Redundancy states (encoding is visible on state_o)
  localparam logic [1:0] c_red_nominal  = 2'b00;
  localparam logic [1:0] c_red_degraded = 2'b01;
  localparam logic [1:0] c_red_fatal    = 2'b10;

  // Cfg sequencer states
  localparam logic [1:0] c_cfg_idle  = 2'b00;
  localparam logic [1:0] c_cfg_drive = 2'b01;
  localparam logic [1:0] c_cfg_ack   = 2'b10;
  localparam logic [1:0] c_cfg_wait  = 2'b11;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  logic [1:0]           r_red_state;
  logic [c_run_w-1:0]   r_run_cnt;
  logic [1:0]           r_cfg_state;
  logic [2:0]           r_mask;
  logic                 r_cfg_err;
  logic [c_hold_w-1:0]  r_hold_cnt;
  logic [ERR_CNT_W-1:0] r_det_cnt;
  logic [ERR_CNT_W-1:0] r_corr_cnt;

  logic [1:0]           w_nb;
  logic [c_run_w-1:0]   w_run_nxt;
  logic                 w_uncorr;
  logic                 w_lost;
  logic [1:0]           w_red_nxt;
  logic                 w_reject;

  assign w_nb = popcount3(is_broken_i);

  // Consecutive detected-but-uncorrected cycles, saturating at the limit.
  // The updated value is used so FATAL appears one cycle after the
  // UNCORR_LIMIT-th bad cycle, like every other input-driven transition.
  always_comb begin
    w_run_nxt = '0;
    if (err_detected_i && !err_corrected_i) begin
      if (r_run_cnt == c_run_max) begin
        w_run_nxt = r_run_cnt;
      end else begin
        w_run_nxt = r_run_cnt + 1'b1;
      end
    end
  end

  assign w_uncorr = (w_run_nxt == c_run_max);
  assign w_lost   = (w_nb >= 2'd2) || w_uncorr;

  always_comb begin
    w_red_nxt = r_red_state;
    case (r_red_state)
      c_red_nominal: begin
        if (w_lost)             w_red_nxt = c_red_fatal;
        else if (w_nb == 2'd1)  w_red_nxt = c_red_degraded;
      end
      c_red_degraded: begin
        if (w_lost)             w_red_nxt = c_red_fatal;
        else if (w_nb == 2'd0)  w_red_nxt = c_red_nominal;
      end
      c_red_fatal:              w_red_nxt = c_red_fatal;
      // Unused encoding: fail safe
      default:                  w_red_nxt = c_red_fatal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_red_state <= c_red_nominal;
      r_run_cnt   <= '0;
    end else begin
      r_red_state <= w_red_nxt;
      r_run_cnt   <= w_run_nxt;
    end
  end

  // A retirement is refused if it retires nothing, would leave fewer than
  // two healthy replicas, or redundancy is already lost.
  assign w_reject = (cfg_mask_i == 3'b000) ||
                    (popcount3(cfg_mask_i | is_broken_i) >= 2'd2) ||
                    (r_red_state == c_red_fatal);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_state <= c_cfg_idle;
      r_mask      <= '0;
      r_cfg_err   <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      case (r_cfg_state)
        c_cfg_idle: begin
          if (cfg_req_i) begin
            r_mask      <= cfg_mask_i;
            r_cfg_err   <= w_reject;
            r_hold_cnt  <= '0;
            r_cfg_state <= w_reject ? c_cfg_ack : c_cfg_drive;
          end
        end
        c_cfg_drive: begin
          if (r_hold_cnt == c_hold_last) begin
            r_cfg_state <= c_cfg_ack;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        c_cfg_ack: begin
          r_cfg_state <= c_cfg_wait;
        end
        c_cfg_wait: begin
          // Requester must drop the level before the next request
          if (!cfg_req_i) r_cfg_state <= c_cfg_idle;
        end
        default: r_cfg_state <= c_cfg_idle;
      endcase
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_det_cnt  <= '0;
      r_corr_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_det_cnt  <= '0;
      r_corr_cnt <= '0;
    end else begin
      if (err_detected_i && (r_det_cnt != c_cnt_max))   r_det_cnt  <= r_det_cnt + 1'b1;
      if (err_corrected_i && (r_corr_cnt != c_cnt_max)) r_corr_cnt <= r_corr_cnt + 1'b1;
    end
  end

  // All outputs are decoded from registers only
  assign set_broken_o = (r_cfg_state == c_cfg_drive) ? r_mask : 3'b000;
  assign cfg_ack_o    = (r_cfg_state == c_cfg_ack);
  assign cfg_err_o    = (r_cfg_state == c_cfg_ack) && r_cfg_err;
  assign state_o      = r_red_state;
  assign halt_req_o   = (r_red_state == c_red_fatal);
  assign det_cnt_o    = r_det_cnt;
  assign corr_cnt_o   = r_corr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_ft_redundancy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_ft_redundancy_ctrl
// Purpose  : Self-checking bench for cv32e40p_ft_redundancy_ctrl. Directed
//            scenarios followed by randomized traffic, compared every cycle
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_ft_redundancy_ctrl;

  localparam int CW   = 4;
  localparam int LIM  = 4;
  localparam int HOLD = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    brk;
  logic          det;
  logic          corr;
  logic          req;
  logic [2:0]    mask;
  logic          clr;
  logic          cfg_ack;
  logic          cfg_err;
  logic [2:0]    set_broken;
  logic [1:0]    state;
  logic          halt_req;
  logic [CW-1:0] det_cnt;
  logic [CW-1:0] corr_cnt;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cv32e40p_ft_redundancy_ctrl #(
    .ERR_CNT_W    (CW),
    .UNCORR_LIMIT (LIM),
    .FORCE_HOLD   (HOLD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .is_broken_i     (brk),
    .err_detected_i  (det),
    .err_corrected_i (corr),
    .cfg_req_i       (req),
    .cfg_mask_i      (mask),
    .cfg_ack_o       (cfg_ack),
    .cfg_err_o       (cfg_err),
    .set_broken_o    (set_broken),
    .state_o         (state),
    .halt_req_o      (halt_req),
    .det_cnt_o       (det_cnt),
    .corr_cnt_o      (corr_cnt),
    .clr_cnt_i       (clr)
  );

  // Reference model: the handshake is a queue of per-cycle output items
  // scheduled when a request is decided.
  typedef struct {
    logic [2:0] sb;
    bit         ack;
    bit         err;
    bit         gap;
  } item_t;

  item_t q[$];
  bit    m_waiting;
  int    m_state, m_run, m_det, m_corr;
  logic [2:0] e_sb;
  bit    e_ack, e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    item_t it;
    int nb;
    bit reject;
    e_sb = 3'b000; e_ack = 0; e_err = 0;
    if (rst) begin
      m_state = 0; m_run = 0; m_det = 0; m_corr = 0;
      q.delete(); m_waiting = 0;
      return;
    end
    // Handshake (decision uses the state before this edge)
    if (q.size() == 0 && !m_waiting && req) begin
      reject = (mask == 3'b000) || ($countones(mask | brk) >= 2) || (m_state == 2);
      if (reject) begin
        q.push_back('{sb: 3'b000, ack: 1, err: 1, gap: 0});
      end else begin
        for (int i = 0; i < HOLD; i++) q.push_back('{sb: mask, ack: 0, err: 0, gap: 0});
        q.push_back('{sb: 3'b000, ack: 1, err: 0, gap: 0});
      end
      q.push_back('{sb: 3'b000, ack: 0, err: 0, gap: 1});
    end else if (q.size() == 0 && m_waiting && !req) begin
      m_waiting = 0;
    end
    if (q.size() > 0) begin
      it = q.pop_front();
      e_sb = it.sb; e_ack = it.ack; e_err = it.err;
      if (it.gap) m_waiting = 1;
    end
    // Redundancy
    nb = $countones(brk);
    if (det && !corr) m_run = (m_run < LIM) ? m_run + 1 : LIM;
    else              m_run = 0;
    if (m_state != 2) begin
      if (nb >= 2 || m_run >= LIM) m_state = 2;
      else                         m_state = nb;
    end
    // Statistics
    if (clr) begin
      m_det = 0; m_corr = 0;
    end else begin
      if (det  && m_det  < CMAX) m_det++;
      if (corr && m_corr < CMAX) m_corr++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("state", 32'(state), 32'(m_state));
    check("halt", 32'(halt_req), 32'(m_state == 2));
    check("set_broken", 32'(set_broken), 32'(e_sb));
    check("ack", 32'(cfg_ack), 32'(e_ack));
    if (e_ack) check("err", 32'(cfg_err), 32'(e_err));
    check("det_cnt", 32'(det_cnt), 32'(m_det));
    check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; brk = '0; det = 0; corr = 0; req = 0; mask = '0; clr = 0;
    do_reset();

    // Quiet operation
    ticks(100);

    // Degrade then lose redundancy; FATAL is sticky
    brk = 3'b001; tick();
    brk = 3'b011; tick();
    brk = 3'b000; ticks(3);
    do_reset();

    // Uncorrected run broken by one corrected cycle, then a full run
    det = 1; corr = 0; ticks(3);
    corr = 1; tick();
    corr = 0; ticks(4);
    det = 0; ticks(2);
    do_reset();

    // Accepted retirement, held request, then a second request
    req = 1; mask = 3'b100; ticks(8);
    req = 0; ticks(2);
    req = 1; ticks(6);
    req = 0; ticks(2);
    do_reset();

    // Rejected requests
    brk = 3'b001; tick();
    req = 1; mask = 3'b010; ticks(5);
    req = 0; ticks(2);
    req = 1; mask = 3'b000; ticks(5);
    req = 0; brk = 3'b000; ticks(2);
    do_reset();

    // Counter saturation and clear priority
    det = 1; ticks(20);
    clr = 1; tick();
    clr = 0; det = 0; ticks(2);

    // Reset in the middle of a forced-break pulse
    req = 1; mask = 3'b001; ticks(2);
    rst = 1; tick();
    rst = 0; req = 0; ticks(5);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 39) == 0) brk = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 15) == 0) brk = 3'b000;
      det  = ($urandom_range(0, 1) == 0);
      corr = det ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 15) == 0);
      if (req) req = ($urandom_range(0, 7) != 0);
      else     req = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) mask = 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
